// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: opcode field, terminator opcode, state encoding.
package program_loader_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] TERM_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_RUN       = 3'd5
  } state_e;

  // True when the word carries the end-of-program opcode.
  function automatic logic is_term(input logic [DATA_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == TERM_OPCODE;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Streams host instruction words into instruction memory, then launches the CPU
// sequencer and waits for it to finish before accepting a new program.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              LoadValid,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadReady,
  input  logic              End,
  output logic              MemWriteEnable,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              ProgramStart,
  output logic [ADDR_W:0]   WordCount,
  output logic              Error
);

  localparam logic [ADDR_W:0]   WC_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   WC_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  state_e              state, state_d;
  logic                beat, term;
  logic                we_d, start_d, err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic [ADDR_W:0]     wc_d, wc_base;

  // Ready depends on End in the same cycle so a busy CPU blocks the beat at once.
  assign LoadReady = ResetN & End & ((state == ST_IDLE) | (state == ST_LOAD));
  assign beat      = LoadValid & LoadReady;
  assign term      = is_term(LoadData);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    we_d    = 1'b0;
    addr_d  = MemAddress;
    data_d  = MemWriteData;
    wc_d    = WordCount;
    wc_base = WordCount;
    err_d   = Error;
    start_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (beat) begin
          wc_base = '0;
          err_d   = 1'b0;
          state_d = term ? ST_FLUSH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          if (term) begin
            state_d = ST_FLUSH;
          end else if (WordCount == WC_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH:     state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!End) state_d = ST_RUN;
      ST_RUN:       if (End) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (beat) begin
      we_d   = 1'b1;
      addr_d = BASE + wc_base[ADDR_W-1:0];
      data_d = LoadData;
      wc_d   = (wc_base == WC_FULL) ? wc_base : wc_base + WC_ONE;
    end

    start_d = (state_d == ST_START);
  end

  // State and registered outputs.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state          <= ST_IDLE;
      MemWriteEnable <= 1'b0;
      MemAddress     <= BASE;
      MemWriteData   <= '0;
      ProgramStart   <= 1'b0;
      WordCount      <= '0;
      Error          <= 1'b0;
    end else begin
      state          <= state_d;
      MemWriteEnable <= we_d;
      MemAddress     <= addr_d;
      MemWriteData   <= data_d;
      ProgramStart   <= start_d;
      WordCount      <= wc_d;
      Error          <= err_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed scenarios plus random traffic.
module tb_program_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned BASE  = 0;

  logic          Clock;
  logic          ResetN;
  logic          LoadValid;
  logic [31:0]   LoadData;
  logic          LoadReady;
  logic          End;
  logic          MemWriteEnable;
  logic [AW-1:0] MemAddress;
  logic [31:0]   MemWriteData;
  logic          ProgramStart;
  logic [AW:0]   WordCount;
  logic          Error;

  program_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .Clock(Clock), .ResetN(ResetN), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadReady(LoadReady), .End(End), .MemWriteEnable(MemWriteEnable),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .ProgramStart(ProgramStart), .WordCount(WordCount), .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   cnt;
    time           t;
  } wr_t;

  typedef struct {
    logic [AW:0] cnt;
    time         t;
  } st_t;

  wr_t wq[$];
  st_t sq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = accepting words, 1/2 = launching, 3 = waiting for
  // CPU to go busy, 4 = waiting for CPU to go idle again.
  int m_phase = 0;
  bit m_fresh = 1'b1;
  int m_count = 0;
  bit m_err   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic e, input time t);
    wr_t w;
    st_t s;
    logic [5:0] opc;
    opc = d[31:26];
    case (m_phase)
      0: if (v && e) begin
        if (m_fresh) begin
          m_count = 0;
          m_err   = 1'b0;
          m_fresh = 1'b0;
        end
        w.addr  = AW'((BASE + m_count) % DEPTH);
        m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
        w.data  = d;
        w.cnt   = (AW+1)'(m_count);
        w.t     = t + 5;
        wq.push_back(w);
        if (opc == 6'h3F) begin
          m_phase = 1;
          s.cnt   = (AW+1)'(m_count);
          s.t     = t + 15;
          sq.push_back(s);
        end else if (m_count == DEPTH) begin
          m_err   = 1'b1;
          m_fresh = 1'b1;
        end
      end
      1: m_phase = 2;
      2: m_phase = 3;
      3: if (!e) m_phase = 4;
      default: if (e) begin
        m_phase = 0;
        m_fresh = 1'b1;
      end
    endcase
  endtask

  // One clock of stimulus: drive, check live status, let the edge happen, update model.
  task automatic step(input logic v, input logic [31:0] d, input logic e);
    logic rdy;
    time  t;
    LoadValid = v;
    LoadData  = d;
    End       = e;
    rdy = (m_phase == 0) && e;
    #1;
    chk("load_ready", 64'(LoadReady), 64'(rdy));
    chk("word_count", 64'(WordCount), 64'(m_count));
    chk("error", 64'(Error), 64'(m_err));
    @(posedge Clock);
    t = $time;
    model_edge(v, d, e, t);
    @(negedge Clock);
  endtask

  task automatic check_reset_values();
    chk("rst_load_ready", 64'(LoadReady), 64'(0));
    chk("rst_we", 64'(MemWriteEnable), 64'(0));
    chk("rst_addr", 64'(MemAddress), 64'(BASE));
    chk("rst_data", 64'(MemWriteData), 64'(0));
    chk("rst_start", 64'(ProgramStart), 64'(0));
    chk("rst_count", 64'(WordCount), 64'(0));
    chk("rst_error", 64'(Error), 64'(0));
  endtask

  task automatic do_reset();
    #2;
    ResetN = 1'b0;
    #1;
    check_reset_values();
    m_phase = 0;
    m_fresh = 1'b1;
    m_count = 0;
    m_err   = 1'b0;
    wq.delete();
    sq.delete();
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  // Launch cycles, then CPU busy for three cycles, then idle again.
  task automatic finish_run();
    repeat (2) step(1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
  endtask

  // Output monitor: every write strobe and start pulse must match a queued expectation.
  initial begin
    wr_t w;
    st_t s;
    forever begin
      @(negedge Clock);
      if (ResetN) begin
        if (MemWriteEnable) begin
          if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected at %0t",
                     MemAddress, MemWriteData, $time);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", 64'(MemAddress), 64'(w.addr));
            chk("wr_data", 64'(MemWriteData), 64'(w.data));
            chk("wr_count", 64'(WordCount), 64'(w.cnt));
            chk("wr_time", 64'($time), 64'(w.t));
          end
        end
        if (ProgramStart) begin
          if (sq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_start: pulse with count %0d, none expected at %0t",
                     WordCount, $time);
          end else begin
            s = sq.pop_front();
            chk("start_count", 64'(WordCount), 64'(s.cnt));
            chk("start_time", 64'($time), 64'(s.t));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        v, e;
    ResetN    = 1'b0;
    LoadValid = 1'b0;
    LoadData  = 32'h0;
    End       = 1'b1;
    #3;
    check_reset_values();
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;

    // Three-word program, back to back.
    step(1'b1, 32'h0000_0001, 1'b1);
    step(1'b1, 32'h0000_0002, 1'b1);
    step(1'b1, 32'hFC00_0000, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1);

    // CPU busy: offers are ignored until it returns idle.
    repeat (5) step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'h1111_1111, 1'b1);
    step(1'b1, 32'h2222_2222, 1'b1);
    step(1'b1, 32'hFC00_00AA, 1'b1);
    finish_run();

    // Memory filled without terminator, then a fresh beat clears Error.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0005, 1'b1);
    step(1'b1, 32'hFC00_0001, 1'b1);
    finish_run();

    // Single-word program.
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    finish_run();

    // Reset in the middle of a load abandons it.
    step(1'b1, 32'h0000_0AAA, 1'b1);
    step(1'b1, 32'h0000_0BBB, 1'b1);
    do_reset();
    step(1'b1, 32'h0000_0CCC, 1'b1);
    step(1'b1, 32'hFC00_0CCC, 1'b1);
    finish_run();

    // Gaps in LoadValid produce no extra writes.
    step(1'b1, 32'h0000_0001, 1'b1);
    step(1'b0, 32'h0000_0001, 1'b1);
    step(1'b1, 32'hFC00_0000, 1'b1);
    step(1'b0, 32'hFC00_0000, 1'b1);
    finish_run();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      if ($urandom_range(3) == 0) d[31:26] = 6'h3F;
      v = ($urandom_range(1) == 1);
      e = ($urandom_range(3) != 0);
      step(v, d, e);
    end
    for (int i = 0; i < 20; i++) begin
      if (m_phase != 0) step(1'b0, 32'h0, (m_phase == 3) ? 1'b0 : 1'b1);
    end
    repeat (3) step(1'b0, 32'h0, 1'b1);

    chk("pending_writes", 64'(wq.size()), 64'(0));
    chk("pending_starts", 64'(sq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (2^ADDR_W words).
REQ-002 Parameter BASE_ADDR, default 0, first instruction-memory word address written.
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 ResetN  input  1  reset, asynchronous, active-low.
REQ-005 LoadValid  input  1  host offers an instruction word.
REQ-006 LoadData  input  32  offered instruction word; bits [31:26] are the opcode.
REQ-007 LoadReady  output  1  loader accepts the word this cycle.
REQ-008 End  input  1  CPU sequencer idle flag: high = idle, low = executing.
REQ-009 MemWriteEnable  output  1  instruction-memory write strobe.
REQ-010 MemAddress  output  ADDR_W  instruction-memory word address.
REQ-011 MemWriteData  output  32  instruction-memory write data.
REQ-012 ProgramStart  output  1  one-cycle start pulse to the CPU sequencer.
REQ-013 WordCount  output  ADDR_W+1  words written in the current/last load, terminator included.
REQ-014 Error  output  1  sticky flag: memory filled without a terminator.

Function
REQ-015 States SHALL be IDLE, LOAD, FLUSH, START, WAIT_BUSY, RUN.
REQ-016 Beat = LoadValid & LoadReady at a rising edge; LoadReady SHALL be high only in IDLE, or in LOAD, and only while End is high.
REQ-017 Per beat, the next cycle SHALL have MemWriteEnable=1, MemAddress=BASE_ADDR+WordCount (pre-increment, modulo 2^ADDR_W), MemWriteData=LoadData; otherwise MemWriteEnable=0, address and data held.
REQ-018 WordCount SHALL increment by 1 per beat and saturate at 2^ADDR_W.
REQ-019 IDLE: first beat clears WordCount to 0 before counting it, clears Error, goes to LOAD (or FLUSH if it is a terminator).
REQ-020 Terminator = beat with LoadData[31:26]==6'b111111; it is written like any word, then the state goes to FLUSH.
REQ-021 LOAD: a non-terminator beat writing the last address (WordCount becomes 2^ADDR_W) SHALL set Error and return to IDLE without ProgramStart.
REQ-022 FLUSH SHALL last exactly one cycle (terminator write completes), then START.
REQ-023 START SHALL last exactly one cycle with ProgramStart=1, then WAIT_BUSY; ProgramStart SHALL be 0 in all other states.
REQ-024 WAIT_BUSY: stay until End==0, then RUN.
REQ-025 RUN: stay until End==1, then IDLE; WordCount held for inspection.
REQ-026 LoadValid outside IDLE/LOAD, or with End low, SHALL be ignored: no write, no count change.
REQ-027 Latency: terminator beat at edge N -> write strobe in cycle N..N+1 -> ProgramStart high in cycle N+1..N+2.

Reset
REQ-028 ResetN low SHALL force, asynchronously: state IDLE, LoadReady=0 until release (then per REQ-016), MemWriteEnable=0, MemAddress=BASE_ADDR, MemWriteData=0, ProgramStart=0, WordCount=0, Error=0.
REQ-029 Reset during LOAD/FLUSH/START SHALL abandon the partial program; no ProgramStart follows.

Structure
REQ-030 Shared package SHALL hold the terminator opcode constant 6'b111111, the opcode field position [31:26], and the loader state encoding.
REQ-031 Single module; no sub-module.

Verification
REQ-032 Load 3 words 0x00000001, 0x00000002, 0xFC000000 back-to-back, End=1 -> writes at addresses 0,1,2; ProgramStart one pulse 2 cycles after third beat; WordCount=3.
REQ-033 After REQ-032, drive End low 5 cycles then high, offering LoadValid throughout -> LoadReady=0, no writes until RUN->IDLE; next beat writes address 0.
REQ-034 ADDR_W=2, four non-terminator words -> writes at addresses 0..3, Error=1, WordCount=4, no ProgramStart; a following beat clears Error.
REQ-035 Single-word program 0xFFFFFFFF -> write at address 0, ProgramStart pulse, WordCount=1.
REQ-036 ResetN low one cycle after second of three words -> all outputs per REQ-028 immediately, no ProgramStart; a reload starts at address 0.
REQ-037 LoadValid toggling 1,0,1,0 with words 0x1, 0xFC000000 -> exactly 2 writes, counts 1 then 2, no duplicate on idle cycles.
